// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit for the in-order pipeline.
// Define FWD_STATS_EN to add the stat_fwd / stat_stall / stat_flush event counters.
module fwd_hazard_unit #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int DEPTH    = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_load,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic              ex_valid,
    output logic              stall,
    output logic [3:0]        fwd_sel1,
    output logic [3:0]        fwd_sel2
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]       stat_fwd,
    output logic [31:0]       stat_stall,
    output logic [31:0]       stat_flush
`endif
);

    logic              ent_valid_q [DEPTH];
    logic              ent_valid_d [DEPTH];
    logic [REG_AW-1:0] ent_rd_q    [DEPTH];
    logic [REG_AW-1:0] ent_rd_d    [DEPTH];
    logic              ent_wr_q    [DEPTH];
    logic              ent_wr_d    [DEPTH];
    logic [DATA_W-1:0] ent_data_q  [1:DEPTH-1];
    logic [DATA_W-1:0] ent_data_d  [1:DEPTH-1];
    logic              ent0_load_q, ent0_load_d;
    logic              ent1_load_q, ent1_load_d;
    logic [DATA_W-1:0] ent_eff     [DEPTH];

    logic [DATA_W-1:0] ex_op1_q, ex_op1_d, ex_op2_q, ex_op2_d;
    logic              ex_valid_q, ex_valid_d;
    logic [3:0]        fwd_sel1_q, fwd_sel1_d, fwd_sel2_q, fwd_sel2_d;

    logic              m1_0, m2_0, stall_c, issue;
    logic [DATA_W-1:0] op1_c, op2_c;
    logic [3:0]        sel1_c, sel2_c;

    function automatic logic hit(input logic v, input logic w, input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] s, input logic u);
        return v && w && u && (rd == s) && !((ZERO_REG != 0) && (s == '0));
    endfunction

    // Effective result per entry: entry 0 is live ALU output, a load in entry 1 takes memory data.
    always_comb begin
        ent_eff[0] = ex_result;
        for (int k = 1; k < DEPTH; k++) ent_eff[k] = ent_data_q[k];
        if (ent1_load_q) ent_eff[1] = mem_rdata;
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        op1_c  = rf_rdata1;
        op2_c  = rf_rdata2;
        sel1_c = '0;
        sel2_c = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit(ent_valid_q[k], ent_wr_q[k], ent_rd_q[k], id_rs1, id_use1)) begin
                op1_c  = ent_eff[k];
                sel1_c = 4'(k + 1);
            end
            if (hit(ent_valid_q[k], ent_wr_q[k], ent_rd_q[k], id_rs2, id_use2)) begin
                op2_c  = ent_eff[k];
                sel2_c = 4'(k + 1);
            end
        end
        if ((ZERO_REG != 0) && (id_rs1 == '0)) op1_c = '0;
        if ((ZERO_REG != 0) && (id_rs2 == '0)) op2_c = '0;
    end

    assign m1_0    = hit(ent_valid_q[0], ent_wr_q[0], ent_rd_q[0], id_rs1, id_use1);
    assign m2_0    = hit(ent_valid_q[0], ent_wr_q[0], ent_rd_q[0], id_rs2, id_use2);
    assign stall_c = reset && id_valid && !flush && ent0_load_q && (m1_0 || m2_0);
    assign issue   = id_valid && !stall_c && !flush;

    always_comb begin
        ent_valid_d[0] = issue;
        ent_rd_d[0]    = id_rd;
        ent_wr_d[0]    = id_regwrite;
        ent0_load_d    = id_load;
        // A flushed entry 0 never reaches entry 1.
        ent_valid_d[1] = ent_valid_q[0] && !flush;
        ent_rd_d[1]    = ent_rd_q[0];
        ent_wr_d[1]    = ent_wr_q[0];
        ent1_load_d    = ent0_load_q;
        ent_data_d[1]  = ex_result;
        for (int k = 2; k < DEPTH; k++) begin
            ent_valid_d[k] = ent_valid_q[k-1];
            ent_rd_d[k]    = ent_rd_q[k-1];
            ent_wr_d[k]    = ent_wr_q[k-1];
            ent_data_d[k]  = ent_eff[k-1];
        end
        ex_valid_d = issue;
        ex_op1_d   = issue ? op1_c  : ex_op1_q;
        ex_op2_d   = issue ? op2_c  : ex_op2_q;
        fwd_sel1_d = issue ? sel1_c : fwd_sel1_q;
        fwd_sel2_d = issue ? sel2_c : fwd_sel2_q;
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_valid_d[k] = 1'b0;
                ent_rd_d[k]    = '0;
                ent_wr_d[k]    = 1'b0;
            end
            for (int k = 1; k < DEPTH; k++) ent_data_d[k] = '0;
            ent0_load_d = 1'b0;
            ent1_load_d = 1'b0;
            ex_valid_d  = 1'b0;
            ex_op1_d    = '0;
            ex_op2_d    = '0;
            fwd_sel1_d  = '0;
            fwd_sel2_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        ent_valid_q <= ent_valid_d;
        ent_rd_q    <= ent_rd_d;
        ent_wr_q    <= ent_wr_d;
        ent_data_q  <= ent_data_d;
        ent0_load_q <= ent0_load_d;
        ent1_load_q <= ent1_load_d;
        ex_valid_q  <= ex_valid_d;
        ex_op1_q    <= ex_op1_d;
        ex_op2_q    <= ex_op2_d;
        fwd_sel1_q  <= fwd_sel1_d;
        fwd_sel2_q  <= fwd_sel2_d;
    end

    assign ex_op1   = ex_op1_q;
    assign ex_op2   = ex_op2_q;
    assign ex_valid = ex_valid_q;
    assign stall    = stall_c;
    assign fwd_sel1 = fwd_sel1_q;
    assign fwd_sel2 = fwd_sel2_q;

`ifdef FWD_STATS_EN
    logic [31:0] stat_fwd_q, stat_fwd_d, stat_stall_q, stat_stall_d, stat_flush_q, stat_flush_d;

    always_comb begin
        stat_fwd_d   = stat_fwd_q + 32'(issue && ((sel1_c != '0) || (sel2_c != '0)));
        stat_stall_d = stat_stall_q + 32'(stall_c);
        stat_flush_d = stat_flush_q + 32'(flush && id_valid);
        if (!reset) begin
            stat_fwd_d   = '0;
            stat_stall_d = '0;
            stat_flush_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        stat_fwd_q   <= stat_fwd_d;
        stat_stall_q <= stat_stall_d;
        stat_flush_q <= stat_flush_d;
    end

    assign stat_fwd   = stat_fwd_q;
    assign stat_stall = stat_stall_q;
    assign stat_flush = stat_flush_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed per-cycle vector bench for fwd_hazard_unit (default parameters).
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        reset, id_valid, id_use1, id_use2, id_regwrite, id_load, flush;
    logic [3:0]  id_rs1, id_rs2, id_rd;
    logic [15:0] rf_rdata1, rf_rdata2, ex_result, mem_rdata;
    logic [15:0] ex_op1, ex_op2;
    logic        ex_valid, stall;
    logic [3:0]  fwd_sel1, fwd_sel2;
`ifdef FWD_STATS_EN
    logic [31:0] stat_fwd, stat_stall, stat_flush;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fwd_hazard_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_load(id_load),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_result(ex_result), .mem_rdata(mem_rdata), .flush(flush),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_valid(ex_valid), .stall(stall),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2)
`ifdef FWD_STATS_EN
        , .stat_fwd(stat_fwd), .stat_stall(stat_stall), .stat_flush(stat_flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, vld;
        logic [3:0]  rs1, rs2;
        logic        u1, u2;
        logic [3:0]  rd;
        logic        wr, ld;
        logic [15:0] rf1, rf2, exr, mem;
        logic        fl;
        logic        e_stall, e_vld;
        logic [15:0] e_op1, e_op2;
        logic [3:0]  e_s1, e_s2;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic vld, input logic [3:0] rs1, input logic [3:0] rs2,
        input logic u1, input logic u2, input logic [3:0] rd, input logic wr, input logic ld,
        input logic [15:0] rf1, input logic [15:0] rf2, input logic [15:0] exr,
        input logic [15:0] mem, input logic fl, input logic e_stall, input logic e_vld,
        input logic [15:0] e_op1, input logic [15:0] e_op2, input logic [3:0] e_s1,
        input logic [3:0] e_s2);
        vec_t v;
        v.rst = rst; v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.wr = wr; v.ld = ld; v.rf1 = rf1; v.rf2 = rf2; v.exr = exr;
        v.mem = mem; v.fl = fl; v.e_stall = e_stall; v.e_vld = e_vld;
        v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_s1 = e_s1; v.e_s2 = e_s2;
        return v;
    endfunction

    task automatic chk(input string name, input string tag, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s[%0d]: got %h expected %h", name, tag, idx, act, exp);
        end
    endtask

    // Drive one ID cycle, check stall before the edge and registered outputs after it.
    task automatic apply(input vec_t v, input string tag, input int idx);
        reset = v.rst; id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_use1 = v.u1; id_use2 = v.u2; id_rd = v.rd; id_regwrite = v.wr;
        id_load = v.ld; rf_rdata1 = v.rf1; rf_rdata2 = v.rf2; ex_result = v.exr;
        mem_rdata = v.mem; flush = v.fl;
        #1;
        chk("stall", tag, idx, {15'd0, stall}, {15'd0, v.e_stall});
        @(posedge clk);
        #1;
        chk("ex_valid", tag, idx, {15'd0, ex_valid}, {15'd0, v.e_vld});
        chk("ex_op1", tag, idx, ex_op1, v.e_op1);
        chk("ex_op2", tag, idx, ex_op2, v.e_op2);
        chk("fwd_sel1", tag, idx, {12'd0, fwd_sel1}, {12'd0, v.e_s1});
        chk("fwd_sel2", tag, idx, {12'd0, fwd_sel2}, {12'd0, v.e_s2});
    endtask

    vec_t tbl [15];
    vec_t seq [7];

    initial begin
        //            rst vld rs1 rs2 u1 u2 rd wr ld rf1      rf2      exr      mem      fl st ev op1      op2      s1 s2
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        tbl[1]  = mk(1, 1, 1, 2, 1, 1, 3,  1, 0, 16'h0011, 16'h0022, 16'h0000, 16'h0000, 0, 0, 1, 16'h0011, 16'h0022, 0, 0);
        tbl[2]  = mk(1, 1, 3, 3, 1, 1, 4,  1, 0, 16'h0999, 16'h0999, 16'h1234, 16'h0000, 0, 0, 1, 16'h1234, 16'h1234, 1, 1);
        tbl[3]  = mk(1, 1, 7, 8, 1, 1, 5,  1, 0, 16'h0007, 16'h0008, 16'h4444, 16'h0000, 0, 0, 1, 16'h0007, 16'h0008, 0, 0);
        tbl[4]  = mk(1, 1, 3, 4, 1, 1, 5,  1, 0, 16'h0101, 16'h0202, 16'h00AA, 16'h0000, 0, 0, 1, 16'h1234, 16'h4444, 3, 2);
        tbl[5]  = mk(1, 1, 5, 4, 1, 1, 6,  1, 0, 16'h0505, 16'h0404, 16'h00BB, 16'h0000, 0, 0, 1, 16'h00BB, 16'h4444, 1, 3);
        tbl[6]  = mk(1, 1, 6, 5, 0, 1, 0,  0, 0, 16'h0606, 16'h0505, 16'h0066, 16'h0000, 0, 0, 1, 16'h0606, 16'h00BB, 0, 2);
        tbl[7]  = mk(1, 1, 1, 0, 1, 0, 2,  1, 1, 16'h0100, 16'h0000, 16'hDEAD, 16'h0000, 0, 0, 1, 16'h0100, 16'h0000, 0, 0);
        tbl[8]  = mk(1, 1, 2, 1, 1, 1, 6,  1, 0, 16'h0222, 16'h0100, 16'h3000, 16'h0000, 0, 1, 0, 16'h0100, 16'h0000, 0, 0);
        tbl[9]  = mk(1, 1, 2, 1, 1, 1, 6,  1, 0, 16'h0222, 16'h0100, 16'h5555, 16'hBEEF, 0, 0, 1, 16'hBEEF, 16'h0100, 2, 0);
        tbl[10] = mk(1, 1, 2, 6, 1, 1, 9,  0, 0, 16'h0222, 16'h0666, 16'h0C0C, 16'h1111, 0, 0, 1, 16'hBEEF, 16'h0C0C, 3, 1);
        tbl[11] = mk(1, 1, 1, 0, 1, 0, 0,  1, 1, 16'h0001, 16'h0000, 16'h7777, 16'h0000, 0, 0, 1, 16'h0001, 16'h0000, 0, 0);
        tbl[12] = mk(1, 1, 0, 0, 1, 1, 10, 1, 0, 16'h0F0F, 16'h0F0F, 16'hFFFF, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
        tbl[13] = mk(1, 1, 0, 6, 1, 1, 11, 0, 0, 16'h0F0F, 16'h0606, 16'h000A, 16'hFFFF, 0, 0, 1, 16'h0000, 16'h0606, 0, 0);
        tbl[14] = mk(1, 0, 10, 0, 1, 1, 12, 1, 1, 16'h0A0A, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0606, 0, 0);

        // Flush colliding with a load-use stall; the killed load must never be forwarded.
        seq[0] = mk(1, 1, 1, 0, 1, 0, 2, 1, 1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 16'h0001, 16'h0000, 0, 0);
        seq[1] = mk(1, 1, 2, 2, 1, 1, 7, 1, 0, 16'h0202, 16'h0202, 16'h9999, 16'h0000, 1, 0, 0, 16'h0001, 16'h0000, 0, 0);
        seq[2] = mk(1, 1, 2, 2, 1, 1, 7, 1, 0, 16'h0202, 16'h0202, 16'h0000, 16'hBAD0, 0, 0, 1, 16'h0202, 16'h0202, 0, 0);
        // Fill the pipe, pulse reset for one cycle, then re-read the same registers.
        seq[3] = mk(1, 1, 1, 2, 0, 0, 3, 1, 0, 16'h0031, 16'h0032, 16'h7007, 16'h0000, 0, 0, 1, 16'h0031, 16'h0032, 0, 0);
        seq[4] = mk(1, 1, 1, 2, 0, 0, 4, 1, 1, 16'h0041, 16'h0042, 16'h3333, 16'h0000, 0, 0, 1, 16'h0041, 16'h0042, 0, 0);
        seq[5] = mk(0, 1, 3, 4, 1, 1, 5, 1, 0, 16'h0303, 16'h0404, 16'h4444, 16'h5555, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        seq[6] = mk(1, 1, 3, 7, 1, 1, 5, 1, 0, 16'h0303, 16'h0707, 16'h1111, 16'h2222, 0, 0, 1, 16'h0303, 16'h0707, 0, 0);

        for (int i = 0; i < 15; i++) apply(tbl[i], "tbl", i);

        apply(seq[0], "flush", 0);
        apply(seq[1], "flush", 1);
        apply(seq[2], "flush", 2);

        apply(seq[3], "reset", 0);
        apply(seq[4], "reset", 1);
        apply(seq[5], "reset", 2);
        apply(seq[6], "reset", 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
